// File: rtl/axis_out_fifo_master.sv
// ---------------------------------------------------------------------------
// axis_out_fifo_master
//
// Transmit-side AXI4-Stream output stage of data_path. Result words from the
// psum/pool packers arrive without any ready signal. They are buffered in a
// FIFO and then launched onto M_AXIS_* with full TREADY backpressure.
// Buffer status is reported so the controller can stall the MAC array before
// words are dropped.
//
// Parameters
//   C_M_AXIS_TDATA_WIDTH : stream data width (multiple of 8)
//   FIFO_DEPTH           : FIFO entries (power of two, >= 4)
//   ALMOST_FULL_MARGIN   : free-entry threshold for almost_full
//   CNT_W                : pointer width; fifo_cnt is CNT_W+1 bits
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_data/in_last   : backpressure-free input stream
//   axis_en                    : permits launching new beats
//   axis_clear                 : synchronous flush of FIFO and output register
//   M_AXIS_TVALID/TDATA/TSTRB/TLAST/TREADY : AXI4-Stream master
//   fifo_cnt/fifo_full/fifo_empty/almost_full : occupancy, output reg excluded
//   overflow                   : sticky, an input word was dropped
//   frame_done                 : one-cycle pulse after a TLAST handshake
//   frame_len                  : beat count of the last completed frame
// ---------------------------------------------------------------------------
module axis_out_fifo_master #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int ALMOST_FULL_MARGIN   = 4,
    parameter int CNT_W                = $clog2(FIFO_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     in_data,
    input  logic                                in_last,
    input  logic                                axis_en,
    input  logic                                axis_clear,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic [CNT_W:0]                      fifo_cnt,
    output logic                                fifo_full,
    output logic                                fifo_empty,
    output logic                                almost_full,
    output logic                                overflow,
    output logic                                frame_done,
    output logic [15:0]                         frame_len
);

    localparam int DW = C_M_AXIS_TDATA_WIDTH;
    localparam int SW = C_M_AXIS_TDATA_WIDTH / 8;

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0] AF_C    = (CNT_W + 1)'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

    typedef enum logic {
        ST_IDLE = 1'b0,   // output register empty
        ST_SEND = 1'b1    // output register holds a beat (TVALID high)
    } state_t;

    // Storage: each entry is {last, data}. No reset on the array; the
    // pointers alone define which entries are live.
    logic [DW:0]        mem [FIFO_DEPTH];

    logic [CNT_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   rd_ptr_reg;
    logic [CNT_W:0]     cnt_reg;
    logic [CNT_W:0]     cnt_next;

    state_t             state_reg;
    logic               out_last_reg;
    logic [DW-1:0]      out_data_reg;

    logic               overflow_reg;
    logic               frame_done_reg;
    logic [15:0]        beat_cnt_reg;
    logic [15:0]        frame_len_reg;

    logic               out_valid;
    logic               full_w;
    logic               empty_w;
    logic               handshake;
    logic               load;
    logic               wr_en;
    logic               drop;
    logic [DW:0]        head;

    assign out_valid = (state_reg == ST_SEND);
    assign full_w    = (cnt_reg == DEPTH_C);
    assign empty_w   = (cnt_reg == '0);
    assign head      = mem[rd_ptr_reg];

    assign handshake = out_valid && M_AXIS_TREADY;

    // A new beat is launched only while the output register is free or is
    // being emptied by a handshake in this same cycle. axis_en gates only
    // launching; an already-presented beat stays up until accepted.
    assign load = axis_en && !empty_w && (!out_valid || M_AXIS_TREADY);

    // When full, a concurrent load frees the head entry, so the incoming
    // word can take its slot (write pointer equals read pointer when full).
    assign wr_en = in_valid && (!full_w || load);
    assign drop  = in_valid && full_w && !load;

    always_comb begin
        cnt_next = cnt_reg;
        case ({wr_en, load})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    // Storage write port. A write during axis_clear lands in a slot that the
    // flushed pointers no longer consider live, so it is harmless.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {in_last, in_data};
        end
    end

    // Output-register state machine plus pointer, occupancy and frame
    // bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            out_last_reg   <= 1'b0;
            out_data_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            cnt_reg        <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            beat_cnt_reg   <= '0;
            frame_len_reg  <= '0;
        end else if (axis_clear) begin
            // Flush wins over any simultaneous write, load or handshake.
            // frame_len is kept so the last finished frame stays readable.
            state_reg      <= ST_IDLE;
            out_last_reg   <= 1'b0;
            out_data_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            cnt_reg        <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            beat_cnt_reg   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            cnt_reg <= cnt_next;

            if (drop) begin
                overflow_reg <= 1'b1;
            end

            // Frame accounting: beat count saturates rather than wrapping.
            frame_done_reg <= 1'b0;
            if (handshake) begin
                if (out_last_reg) begin
                    frame_len_reg  <= (beat_cnt_reg == 16'hFFFF) ? 16'hFFFF
                                                                 : beat_cnt_reg + 16'd1;
                    beat_cnt_reg   <= '0;
                    frame_done_reg <= 1'b1;
                end else if (beat_cnt_reg != 16'hFFFF) begin
                    beat_cnt_reg <= beat_cnt_reg + 16'd1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        state_reg    <= ST_SEND;
                        out_last_reg <= head[DW];
                        out_data_reg <= head[DW-1:0];
                    end
                end
                ST_SEND: begin
                    // In SEND a load implies a handshake, so back-to-back
                    // beats simply replace the register contents.
                    if (load) begin
                        out_last_reg <= head[DW];
                        out_data_reg <= head[DW-1:0];
                    end else if (handshake) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TDATA  = out_data_reg;
    assign M_AXIS_TLAST  = out_last_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_strb
            assign M_AXIS_TSTRB[gi] = 1'b1;
        end
    endgenerate

    assign fifo_cnt    = cnt_reg;
    assign fifo_full   = full_w;
    assign fifo_empty  = empty_w;
    assign almost_full = (cnt_reg >= AF_C);
    assign overflow    = overflow_reg;
    assign frame_done  = frame_done_reg;
    assign frame_len   = frame_len_reg;

endmodule

// File: tb/tb_axis_out_fifo_master.sv
// ---------------------------------------------------------------------------
// tb_axis_out_fifo_master
//
// Directed sequence with randomized data/handshake phases. A queue-based
// reference model (FIFO contents + one presented beat) predicts every output
// each cycle; extra targeted checks cover latency, thresholds and flushes.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axis_out_fifo_master;

    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic            axis_en;
    logic            axis_clear;
    logic            M_AXIS_TVALID;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic [DW/8-1:0] M_AXIS_TSTRB;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY;
    logic [4:0]      fifo_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            almost_full;
    logic            overflow;
    logic            frame_done;
    logic [15:0]     frame_len;

    always #5 clk = ~clk;

    axis_out_fifo_master #(
        .C_M_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH           (DEPTH),
        .ALMOST_FULL_MARGIN   (MARGIN),
        .CNT_W                (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .axis_en       (axis_en),
        .axis_clear    (axis_clear),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .fifo_cnt      (fifo_cnt),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .almost_full   (almost_full),
        .overflow      (overflow),
        .frame_done    (frame_done),
        .frame_len     (frame_len)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [DW:0]   q[$];       // buffered {last, data}, oldest first
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_last;
    bit            m_ovf;
    int            m_beat;
    int            m_flen;
    bit            m_fdone;

    // Observed DUT activity counters.
    int dut_hs = 0;
    int dut_fd = 0;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_ovf   = 1'b0;
        m_beat  = 0;
        m_flen  = 0;
        m_fdone = 1'b0;
    endtask

    task automatic check_all();
        chk("tvalid",      M_AXIS_TVALID, m_valid);
        chk("tdata",       M_AXIS_TDATA,  m_data);
        chk("tlast",       M_AXIS_TLAST,  m_last);
        chk("fifo_cnt",    fifo_cnt,      q.size());
        chk("fifo_full",   fifo_full,     q.size() == DEPTH);
        chk("fifo_empty",  fifo_empty,    q.size() == 0);
        chk("almost_full", almost_full,   q.size() >= DEPTH - MARGIN);
        chk("overflow",    overflow,      m_ovf);
        chk("frame_done",  frame_done,    m_fdone);
        chk("frame_len",   frame_len,     m_flen);
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit          hs;
        bit          ld;
        logic [DW:0] h;
        if (axis_clear) begin
            q.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_last  = 1'b0;
            m_ovf   = 1'b0;
            m_beat  = 0;
            m_fdone = 1'b0;
            return;
        end
        hs = m_valid && M_AXIS_TREADY;
        ld = axis_en && (q.size() > 0) && (!m_valid || M_AXIS_TREADY);
        m_fdone = 1'b0;
        if (hs) begin
            if (m_last) begin
                m_flen  = (m_beat + 1 > 65535) ? 65535 : m_beat + 1;
                m_beat  = 0;
                m_fdone = 1'b1;
            end else if (m_beat < 65535) begin
                m_beat++;
            end
        end
        if (ld) begin
            h       = q.pop_front();
            m_valid = 1'b1;
            m_last  = h[DW];
            m_data  = h[DW-1:0];
        end else if (hs) begin
            m_valid = 1'b0;
        end
        // A load in the same cycle has already freed a slot.
        if (in_valid) begin
            if (q.size() < DEPTH) q.push_back({in_last, in_data});
            else                  m_ovf = 1'b1;
        end
    endtask

    // One clock: compare, log any beat, advance model, move to next falling edge.
    task automatic step();
        check_all();
        if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
            dut_hs++;
            $display("[%0t] beat data=%08h last=%0b", $time, M_AXIS_TDATA, M_AXIS_TLAST);
        end
        if (frame_done === 1'b1) dut_fd++;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        axis_clear = 1'b1;
        step();
        axis_clear = 1'b0;
    endtask

    initial begin
        int            base;
        int            i;
        logic [DW-1:0] hold;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        axis_en       = 1'b0;
        axis_clear    = 1'b0;
        M_AXIS_TREADY = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_tstrb", M_AXIS_TSTRB, 4'hF);
        check_all();
        rst_n = 1'b1;

        // Basic stream: 8 words, TVALID in cycle 2
        axis_en       = 1'b1;
        M_AXIS_TREADY = 1'b1;
        base          = dut_fd;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) chk("basic_tvalid_cycle1", M_AXIS_TVALID, 1'b0);
            if (k == 2) chk("basic_tvalid_cycle2", M_AXIS_TVALID, 1'b1);
            in_valid = 1'b1;
            in_data  = 32'h10 + k;
            in_last  = (k == 7);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (12) step();
        chk("basic_frame_len", frame_len, 16'd8);
        chk("basic_frame_done_pulses", dut_fd - base, 1);

        // Backpressure: 18 words with TREADY low
        M_AXIS_TREADY = 1'b0;
        for (int k = 0; k < 18; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = (k == 16);
            step();
            if (k == 11) chk("bp_almost_full_before", almost_full, 1'b0);
            if (k == 12) chk("bp_almost_full_at_12", almost_full, 1'b1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_cnt_full", fifo_cnt, 5'd16);
        chk("bp_full_flag", fifo_full, 1'b1);
        chk("bp_overflow", overflow, 1'b1);
        M_AXIS_TREADY = 1'b1;
        base = dut_hs;
        repeat (20) step();
        chk("bp_drained_beats", dut_hs - base, 17);
        chk("bp_overflow_sticky", overflow, 1'b1);

        pulse_clear();
        chk("clear_overflow", overflow, 1'b0);

        // Simultaneous write + handshake while full
        M_AXIS_TREADY = 1'b0;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'b0;
            step();
        end
        chk("sim_cnt_before", fifo_cnt, 5'd16);
        in_valid      = 1'b1;
        in_data       = 32'hCAFE_0001;
        M_AXIS_TREADY = 1'b1;
        step();
        in_valid      = 1'b0;
        M_AXIS_TREADY = 1'b0;
        chk("sim_cnt_after", fifo_cnt, 5'd16);
        chk("sim_overflow", overflow, 1'b0);

        // Random traffic and backpressure
        repeat (300) begin
            in_valid      = ($urandom_range(0, 1) == 1);
            in_data       = $urandom;
            in_last       = ($urandom_range(0, 7) == 0);
            axis_en       = ($urandom_range(0, 9) != 0);
            M_AXIS_TREADY = ($urandom_range(0, 1) == 1);
            step();
        end
        in_valid      = 1'b0;
        in_last       = 1'b0;
        axis_en       = 1'b1;
        M_AXIS_TREADY = 1'b1;
        repeat (20) step();
        chk("rand_drained", fifo_empty, 1'b1);

        // axis_en gating
        pulse_clear();
        M_AXIS_TREADY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hA000 + k;
            step();
        end
        in_valid = 1'b0;
        step();
        hold    = M_AXIS_TDATA;
        axis_en = 1'b0;
        repeat (3) step();
        chk("en_hold_tvalid", M_AXIS_TVALID, 1'b1);
        chk("en_hold_tdata", M_AXIS_TDATA, hold);
        M_AXIS_TREADY = 1'b1;
        step();
        chk("en_off_tvalid", M_AXIS_TVALID, 1'b0);
        chk("en_off_nonempty", fifo_empty, 1'b0);
        step();
        chk("en_off_tvalid2", M_AXIS_TVALID, 1'b0);
        axis_en = 1'b1;
        repeat (8) step();
        chk("en_resume_empty", fifo_empty, 1'b1);

        // Clear mid-frame, coincident with an input word
        pulse_clear();
        base = dut_hs;
        i    = 0;
        while ((dut_hs - base) < 5 && i < 20) begin
            in_valid = 1'b1;
            in_data  = 32'hB000 + i;
            in_last  = (i == 9);
            step();
            i++;
        end
        chk("clr_mid_beats", dut_hs - base, 5);
        in_valid   = 1'b1;
        in_data    = 32'hDEAD_BEEF;
        in_last    = 1'b0;
        axis_clear = 1'b1;
        step();
        axis_clear = 1'b0;
        in_valid   = 1'b0;
        chk("clr_tvalid", M_AXIS_TVALID, 1'b0);
        chk("clr_cnt", fifo_cnt, 5'd0);
        chk("clr_overflow", overflow, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hC000 + k;
            in_last  = (k == 2);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (6) step();
        chk("clr_next_frame_len", frame_len, 16'd3);

        // Reset mid-frame
        M_AXIS_TREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_tstrb", M_AXIS_TSTRB, 4'hF);
        chk("rst_mid_frame_len", frame_len, 16'd0);
        check_all();
        @(negedge clk);
        rst_n         = 1'b1;
        M_AXIS_TREADY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hE000 + k;
            in_last  = (k == 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (5) step();
        chk("rst_after_frame_len", frame_len, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_out_fifo_master.md
# axis_out_fifo_master

AXI4-Stream master output stage of `data_path`. It accepts the backpressure-free result stream from the psum/pool packers (`in_valid`/`in_data`/`in_last`) and buffers it in a FIFO. It then drives it onto `M_AXIS_*` with full TREADY backpressure. It is the transmit-side counterpart of the slave-side `axis_fifo_my` input buffer and reports buffer status so the controller can stall the MAC array before data is lost.

## Interface

**Parameters**
- `C_M_AXIS_TDATA_WIDTH`, 32: stream data width.
- `FIFO_DEPTH`, 16: FIFO entries, power of two, ≥4.
- `ALMOST_FULL_MARGIN`, 4: free-entry threshold for `almost_full`.
- `CNT_W`, clogb2(FIFO_DEPTH): width of `fifo_cnt` minus 1.

**Ports**
- `clk` in 1: clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `in_valid` in 1: input word present. There is no ready.
- `in_data` in C_M_AXIS_TDATA_WIDTH: input word.
- `in_last` in 1: last word of a layer frame.
- `axis_en` in 1: permits launching new beats.
- `axis_clear` in 1: synchronous flush.
- `M_AXIS_TVALID` out 1: AXIS valid.
- `M_AXIS_TDATA` out C_M_AXIS_TDATA_WIDTH: AXIS data.
- `M_AXIS_TSTRB` out C_M_AXIS_TDATA_WIDTH/8: constant all-ones.
- `M_AXIS_TLAST` out 1: AXIS last.
- `M_AXIS_TREADY` in 1: AXIS ready.
- `fifo_cnt` out CNT_W+1: FIFO occupancy. Excludes the output register.
- `fifo_full` out 1: `fifo_cnt == FIFO_DEPTH`.
- `fifo_empty` out 1: `fifo_cnt == 0`.
- `almost_full` out 1: `fifo_cnt >= FIFO_DEPTH-ALMOST_FULL_MARGIN`.
- `overflow` out 1: sticky; an input word was dropped.
- `frame_done` out 1: one-cycle pulse on the TLAST handshake.
- `frame_len` out 16: beat count of the last completed frame.

## Operation

**Storage**
- FIFO of `FIFO_DEPTH` entries, each {last, data}.
- Read/write pointers are CNT_W bits and wrap naturally.
- Output register {out_valid, out_last, out_data} drives `M_AXIS_*` directly.

**Write**
- On `in_valid && !fifo_full`, the word is written and `wr_ptr++`.
- On `in_valid && fifo_full`, the word is dropped and `overflow` is set.
- `overflow` clears only on reset or `axis_clear`.

**Load**
- load = `axis_en && !fifo_empty && (!out_valid || M_AXIS_TREADY)`.
- On load, the FIFO head moves into the output register and `rd_ptr++`.

**Handshake**
- A beat transfers when `M_AXIS_TVALID && M_AXIS_TREADY`.
- Without a concurrent load, a handshake clears `out_valid`.
- Once asserted, TVALID/TDATA/TLAST stay stable until the handshake, even if `axis_en` falls.

**Occupancy**
- Write and load in the same cycle leave `fifo_cnt` unchanged.
- A write when the FIFO is full with a simultaneous load is accepted, because load frees an entry.

**State machine** (tracks the output register)
- IDLE (out_valid=0):
  - load goes to SEND.
- SEND (out_valid=1), on handshake:
  - with load, stays in SEND;
  - without load, goes to IDLE.
- Any state: `axis_clear` goes to IDLE.

**Frame counter**
- `beat_cnt` (16b) increments per handshake and saturates at 16'hFFFF.
- On a handshake with TLAST=1:
  - `frame_len` gets `beat_cnt+1` (saturated);
  - `beat_cnt` returns to 0;
  - `frame_done` pulses.

**`axis_clear`**
- Zeroes the pointers, `fifo_cnt`, `out_valid`, `overflow` and `beat_cnt`.
- It has priority over a simultaneous write, load or handshake.
- It may break an in-flight AXIS beat; the controller issues it only between layers.
- It does not change `frame_len`.

## Timing

**Reset values** (`rst_n` low)
- TVALID=0, TDATA=0, TLAST=0, TSTRB=all-ones.
- fifo_cnt=0, fifo_empty=1, fifo_full=0, almost_full=0.
- overflow=0, frame_done=0, frame_len=0.
- State is IDLE. Reset mid-frame discards all data.

**Latency and throughput**
- A word with `in_valid` high in cycle 0 is written at the end of cycle 0.
- It appears with TVALID=1 in cycle 2 when the output is idle and `axis_en`=1.
- Sustained throughput is 1 beat/cycle with TREADY held high.

**Status outputs**
- Status flags are registered or derived from the registered count. They reflect the state after the previous edge.

**Backpressure**
- With TREADY low, the FIFO holds FIFO_DEPTH words plus 1 in the output register.
- The next word is dropped and sets `overflow`.

## Test plan

- **Basic stream:** reset, `axis_en`=1, TREADY=1, push 8 words 0x10..0x17 back-to-back with `in_last` on the 8th.
  - TVALID from cycle 2, words in order, TLAST on 0x17.
  - `frame_done` pulses once and `frame_len`=8.
- **Backpressure and full:** TREADY=0, push 18 words.
  - `fifo_cnt`=16, `fifo_full`=1.
  - `almost_full` rises when `fifo_cnt` reaches 12 (at the end of the 13th word's cycle).
  - Word 18 is dropped and `overflow`=1.
  - Then TREADY=1: 17 words drain in order.
- **Simultaneous events:** with the FIFO full, assert `in_valid` and a handshake in the same cycle.
  - The word is accepted, `fifo_cnt` stays 16 and `overflow` stays 0.
  - Also toggle TREADY randomly: no beat is lost or duplicated and TDATA is stable while TVALID && !TREADY.
- **axis_en gating:** with TVALID=1 and TREADY=0, drop `axis_en`.
  - TVALID and TDATA hold.
  - After one handshake, TVALID=0 while the FIFO is nonempty.
  - Re-enable: streaming resumes.
- **Clear and reset mid-frame:** after 5 of 10 beats, pulse `axis_clear` coincident with `in_valid`.
  - TVALID=0, `fifo_cnt`=0, `overflow`=0; the new word is discarded.
  - The next frame of 3 beats gives `frame_len`=3.
  - Repeat with `rst_n` low mid-frame: all outputs are at their reset values.
